// File: rtl/r2n_buffer_o_if.sv
// Block-in / row-out handshake bundle for r2n_buffer_o.
// Optional out_last signal present only when R2N_LAST_EN is defined.
interface r2n_buffer_o_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ROW        = 256,
   parameter int unsigned COL        = 64,
   parameter int unsigned BLOCK_SIZE = 2,
   parameter int unsigned CHUNK_SIZE = 4
) ();
   localparam int unsigned IN_WIDTH = WIDTH * BLOCK_SIZE * CHUNK_SIZE;
   localparam int unsigned IDX_W    = (ROW > 1) ? $clog2(ROW) : 1;

   logic                   in_valid;
   logic                   in_ready;
   logic [IN_WIDTH-1:0]    in_block;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH*COL-1:0]   out_row;
   logic [IDX_W-1:0]       out_row_idx;
   logic                   band_done;
   logic                   frame_done;
`ifdef R2N_LAST_EN
   logic                   out_last;
`endif

   modport master (
      output in_valid, in_block, out_ready,
      input  in_ready, out_valid, out_row, out_row_idx, band_done, frame_done
`ifdef R2N_LAST_EN
      , input out_last
`endif
   );

   modport slave (
      input  in_valid, in_block, out_ready,
      output in_ready, out_valid, out_row, out_row_idx, band_done, frame_done
`ifdef R2N_LAST_EN
      , output out_last
`endif
   );
endinterface

// File: rtl/r2n_buffer_o.sv
// Ready-to-normal output buffer: reassembles BLOCK_SIZE x CHUNK_SIZE blocks into
// row-major rows through two ping-pong band banks. Optional out_last via R2N_LAST_EN.
module r2n_buffer_o #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned FRAC_WIDTH = 8,
   parameter int unsigned ROW        = 256,
   parameter int unsigned COL        = 64,
   parameter int unsigned BLOCK_SIZE = 2,
   parameter int unsigned CHUNK_SIZE = 4
) (
   input  logic           clk,
   input  logic           rst,
   r2n_buffer_o_if.slave  bus
);
   localparam int unsigned NGRP  = COL / CHUNK_SIZE;
   localparam int unsigned NBAND = ROW / BLOCK_SIZE;
   localparam int unsigned GW    = (NGRP > 1)       ? $clog2(NGRP)       : 1;
   localparam int unsigned BW    = (NBAND > 1)      ? $clog2(NBAND)      : 1;
   localparam int unsigned RW    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int unsigned CW    = (COL > 1)        ? $clog2(COL)        : 1;
   localparam int unsigned IDX_W = (ROW > 1)        ? $clog2(ROW)        : 1;

   if ((ROW % BLOCK_SIZE) != 0 || (COL % CHUNK_SIZE) != 0 || FRAC_WIDTH > WIDTH) begin : g_param_err
      $error("r2n_buffer_o: illegal parameter combination");
   end

   typedef enum logic [1:0] {BK_EMPTY, BK_FILLING, BK_FULL} bank_st_t;

   bank_st_t           bank_st [2];
   logic [WIDTH-1:0]   mem [2][BLOCK_SIZE][COL];
   logic               wb;
   logic               rb;
   logic [GW-1:0]      wgrp;
   logic [RW-1:0]      rrow;
   logic [BW-1:0]      rband;
   logic               band_done;
   logic               frame_done;

   logic [1:0]         full_c;
   logic               in_ready_c;
   logic               out_valid_c;
   logic               accept_c;
   logic               drain_c;
   logic               last_row_c;
   logic [WIDTH*COL-1:0] row_c;
   logic [IDX_W-1:0]   row_idx_c;

   assign full_c      = {bank_st[1] == BK_FULL, bank_st[0] == BK_FULL};
   assign in_ready_c  = !rst && !full_c[wb];
   assign out_valid_c = !rst && full_c[rb];
   assign accept_c    = bus.in_valid && in_ready_c;
   assign drain_c     = out_valid_c && bus.out_ready;
   assign last_row_c  = (rrow == RW'(BLOCK_SIZE - 1));
   assign row_idx_c   = IDX_W'(int'(rband) * BLOCK_SIZE + int'(rrow));

   // Bank fill/drain state, pointers and completion pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) bank_st[b] <= BK_EMPTY;
         wb         <= 1'b0;
         rb         <= 1'b0;
         wgrp       <= '0;
         rrow       <= '0;
         rband      <= '0;
         band_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         band_done  <= drain_c && last_row_c;
         frame_done <= drain_c && last_row_c && (rband == BW'(NBAND - 1));
         if (accept_c) begin
            if (wgrp == GW'(NGRP - 1)) begin
               bank_st[wb] <= BK_FULL;
               wb          <= ~wb;
               wgrp        <= '0;
            end else begin
               bank_st[wb] <= BK_FILLING;
               wgrp        <= wgrp + GW'(1);
            end
         end
         // Drain clears the other bank than any concurrent fill completes.
         if (drain_c) begin
            if (last_row_c) begin
               bank_st[rb] <= BK_EMPTY;
               rb          <= ~rb;
               rrow        <= '0;
               rband       <= (rband == BW'(NBAND - 1)) ? '0 : rband + BW'(1);
            end else begin
               rrow        <= rrow + RW'(1);
            end
         end
      end
   end

   // Block scatter into the write bank; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         for (int r = 0; r < BLOCK_SIZE; r++) begin
            for (int c = 0; c < CHUNK_SIZE; c++) begin
               mem[wb][RW'(r)][CW'(int'(wgrp) * CHUNK_SIZE + c)] <=
                  bus.in_block[(c * BLOCK_SIZE + r) * WIDTH +: WIDTH];
            end
         end
      end
   end

   // Row gather, column 0 at the MSB end.
   always_comb begin
      row_c = '0;
      for (int k = 0; k < COL; k++) begin
         row_c[WIDTH*COL-1-k*WIDTH -: WIDTH] = mem[rb][rrow][CW'(k)];
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.out_row     = row_c;
   assign bus.out_row_idx = row_idx_c;
   assign bus.band_done   = band_done;
   assign bus.frame_done  = frame_done;
`ifdef R2N_LAST_EN
   assign bus.out_last    = out_valid_c && (row_idx_c == IDX_W'(ROW - 1));
`endif
endmodule

// File: tb/tb_r2n_buffer_o.sv
// Self-checking bench for r2n_buffer_o: directed and random traffic against a
// row-queue scoreboard built from the block-to-row mapping.
module tb_r2n_buffer_o;
   localparam int unsigned W     = 16;
   localparam int unsigned ROW   = 4;
   localparam int unsigned COL   = 8;
   localparam int unsigned BS    = 2;
   localparam int unsigned CH    = 4;
   localparam int unsigned NGRP  = COL / CH;
   localparam int unsigned NBAND = ROW / BS;
   localparam int unsigned IDX_W = $clog2(ROW);
   localparam int unsigned DW    = W * COL;

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic [DW-1:0]    data;
   } exp_t;

   logic clk;
   logic rst;
   r2n_buffer_o_if #(.WIDTH(W), .ROW(ROW), .COL(COL), .BLOCK_SIZE(BS), .CHUNK_SIZE(CH)) bus ();

   r2n_buffer_o #(.WIDTH(W), .FRAC_WIDTH(8), .ROW(ROW), .COL(COL),
                  .BLOCK_SIZE(BS), .CHUNK_SIZE(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   exp_t        q[$];
   logic [W-1:0] stage [BS][COL];
   logic [W-1:0] blk   [BS][CH];
   int          wgrp_m = 0;
   int          wband_m = 0;
   bit          exp_bd = 1'b0;
   bit          exp_fd = 1'b0;
   bit          last_acc = 1'b0;
   int          bd_seen = 0;
   int          fd_seen = 0;
   logic [W-1:0] offset = '0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Next block for the model's current band/group; directed value = row*COL+col+offset.
   task automatic set_block(input bit rnd);
      for (int r = 0; r < BS; r++) begin
         for (int c = 0; c < CH; c++) begin
            blk[r][c] = rnd ? W'($urandom)
                            : W'((wband_m * BS + r) * COL + wgrp_m * CH + c) + offset;
            bus.in_block[(c * BS + r) * W +: W] = blk[r][c];
         end
      end
   endtask

   // One clock: check at negedge, then advance the scoreboard at posedge.
   task automatic cycle();
      bit   exp_rdy;
      bit   exp_vld;
      bit   drn;
      exp_t e;
      @(negedge clk);
      exp_vld = (q.size() != 0);
      exp_rdy = ((q.size() + BS - 1) / BS) < 2;
      if (rst) begin
         chk("rst_in_ready", DW'(bus.in_ready), '0);
         chk("rst_out_valid", DW'(bus.out_valid), '0);
      end else begin
         chk("in_ready", DW'(bus.in_ready), DW'(exp_rdy));
         chk("out_valid", DW'(bus.out_valid), DW'(exp_vld));
         chk("band_done", DW'(bus.band_done), DW'(exp_bd));
         chk("frame_done", DW'(bus.frame_done), DW'(exp_fd));
         if (exp_vld) begin
            chk("row_idx", DW'(bus.out_row_idx), DW'(q[0].idx));
            chk("row_data", bus.out_row, q[0].data);
         end
`ifdef R2N_LAST_EN
         chk("out_last", DW'(bus.out_last),
             DW'(exp_vld && (q.size() != 0) && int'(q[0].idx) == ROW - 1));
`endif
         if (bus.band_done === 1'b1) bd_seen++;
         if (bus.frame_done === 1'b1) fd_seen++;
      end
      last_acc = !rst && bus.in_valid && exp_rdy;
      drn      = !rst && bus.out_ready && exp_vld;
      @(posedge clk);
      exp_bd = 1'b0;
      exp_fd = 1'b0;
      if (rst) begin
         q.delete();
         wgrp_m  = 0;
         wband_m = 0;
      end else begin
         if (drn) begin
            e = q.pop_front();
            exp_bd = (int'(e.idx) % BS) == BS - 1;
            exp_fd = int'(e.idx) == ROW - 1;
         end
         if (last_acc) begin
            for (int r = 0; r < BS; r++)
               for (int c = 0; c < CH; c++)
                  stage[r][wgrp_m * CH + c] = blk[r][c];
            if (wgrp_m == NGRP - 1) begin
               for (int r = 0; r < BS; r++) begin
                  e.idx = IDX_W'(wband_m * BS + r);
                  for (int k = 0; k < COL; k++) e.data[DW-1-k*W -: W] = stage[r][k];
                  q.push_back(e);
               end
               wgrp_m  = 0;
               wband_m = (wband_m + 1) % NBAND;
            end else begin
               wgrp_m++;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic send_blocks(input int n, input bit rnd);
      int got = 0;
      int guard = 0;
      set_block(rnd);
      bus.in_valid = 1'b1;
      while (got < n && guard < 200) begin
         cycle();
         guard++;
         if (last_acc) begin
            got++;
            set_block(rnd);
         end
      end
      bus.in_valid = 1'b0;
      chk("send_count", DW'(got), DW'(n));
   endtask

   task automatic drain(input bit rnd);
      int guard = 0;
      bus.in_valid = 1'b0;
      while (q.size() != 0 && guard < 500) begin
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cycle();
         guard++;
      end
      bus.out_ready = 1'b1;
      cycle();
      cycle();
      chk("drain_left", DW'(q.size()), '0);
   endtask

   initial begin
      int got;
      int guard;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_block  = '0;

      // Reset state, then in_ready rises once reset is released.
      do_reset();
      cycle();
      chk("post_rst_ready", DW'(bus.in_ready), DW'(1));

      // Back-to-back stream of one frame with a free-running sink.
      bd_seen = 0; fd_seen = 0;
      bus.out_ready = 1'b1;
      send_blocks(4, 1'b0);
      drain(1'b0);
      chk("bd_count_frame1", DW'(bd_seen), DW'(2));
      chk("fd_count_frame1", DW'(fd_seen), DW'(1));

      // Sink stalled: both banks fill, a further block stalls.
      bus.out_ready = 1'b0;
      send_blocks(4, 1'b0);
      chk("both_full_ready", DW'(bus.in_ready), '0);
      set_block(1'b0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_no_accept", DW'(last_acc), '0);
      end
      bus.out_ready = 1'b1;
      send_blocks(4, 1'b0);
      drain(1'b0);

      // Random valid/ready over three frames.
      fd_seen = 0;
      got = 0; guard = 0;
      set_block(1'b1);
      while (got < 3 * ROW / BS * NGRP && guard < 5000) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         cycle();
         guard++;
         if (last_acc) begin
            got++;
            set_block(1'b1);
         end
      end
      chk("rand_blocks", DW'(got), DW'(3 * ROW / BS * NGRP));
      drain(1'b1);
      chk("rand_fd_count", DW'(fd_seen), DW'(3));

      // Reset mid-frame discards buffered bands.
      bus.out_ready = 1'b0;
      send_blocks(3, 1'b0);
      do_reset();
      offset = 16'h0100;
      bus.out_ready = 1'b1;
      send_blocks(4, 1'b0);
      drain(1'b0);

      // Last row of bank 0 drains while bank 1 takes its last block.
      bus.out_ready = 1'b0;
      send_blocks(3, 1'b0);
      bus.out_ready = 1'b1;
      cycle();
      bus.in_valid = 1'b1;
      cycle();
      chk("simul_accept", DW'(last_acc), DW'(1));
      chk("simul_valid", DW'(bus.out_valid), DW'(1));
      chk("simul_idx", DW'(bus.out_row_idx), DW'(2));
      chk("simul_ready", DW'(bus.in_ready), DW'(1));
      bus.in_valid = 1'b0;
      drain(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/r2n_buffer_o.md
Name: r2n_buffer_o

Overview:
Ready-to-normal buffer for the matmul output path. It is the inverse of the weight n2r buffer. It accepts result blocks of BLOCK_SIZE rows × CHUNK_SIZE columns, emitted in block order by the MAC cores. It reassembles them into full row-major rows of COL elements for downstream row-wise consumers (softmax, layernorm, writeback). Two ping-pong band banks let block intake overlap row drain.

Parameters:
WIDTH, 16, element bit width
FRAC_WIDTH, 8, fractional bits; not used internally, kept for interface consistency
ROW, 256, rows per frame; must be a multiple of BLOCK_SIZE
COL, 64, columns per row; must be a multiple of CHUNK_SIZE
BLOCK_SIZE, 2, rows per input block; one band = BLOCK_SIZE full rows
CHUNK_SIZE, 4, columns per input block
IN_WIDTH, WIDTH*BLOCK_SIZE*CHUNK_SIZE, input block width (derived)

Ports:
clk  in  1  single clock; one clock; reset is synchronous and active-high
rst  in  1  synchronous active-high reset
in_valid  in  1  in_block valid
in_ready  out  1  block accepted when in_valid && in_ready
in_block  in  IN_WIDTH  element (r,c) of block at [(c*BLOCK_SIZE+r)*WIDTH +: WIDTH], with r<BLOCK_SIZE and c<CHUNK_SIZE
out_valid  out  1  out_row valid
out_ready  in  1  row consumed when out_valid && out_ready
out_row  out  WIDTH*COL  row-major row; column k at [WIDTH*COL-1-k*WIDTH -: WIDTH] (column 0 at MSB)
out_row_idx  out  clog2(ROW)  frame row index of out_row
band_done  out  1  1-cycle pulse after last row of a band is consumed
frame_done  out  1  1-cycle pulse after row ROW-1 is consumed

Behaviour:
- Input order: column group fastest (0..COL/CHUNK_SIZE-1), then band (0..ROW/BLOCK_SIZE-1).
- State: banks bank[0..1], each BLOCK_SIZE×COL×WIDTH bits. full[1:0] flags. Write pointer wb, group counter wgrp. Read pointer rb, row-in-band counter rrow. Band counter rband.
- Reset (rst=1 at posedge) resets the following; bank contents are don't-care:
  - full=0, wb=rb=0, wgrp=rrow=rband=0
  - out_valid=0, band_done=0, frame_done=0
  - in_ready is 0 while rst is high and 1 the cycle after.
- Reset mid-frame discards all partial and full bands. Output restarts at row 0.
- Write FSM (per bank):
  - EMPTY → FILLING on first accepted block.
  - FILLING → FULL on accept with wgrp==COL/CHUNK_SIZE-1. Then full[wb]<=1, wb toggles, wgrp<=0.
  - in_ready = !full[wb], which is combinational from registered flags.
  - An accepted block writes bank[wb] columns wgrp*CHUNK_SIZE .. +CHUNK_SIZE-1 of rows 0..BLOCK_SIZE-1.
- Read FSM:
  - out_valid = full[rb].
  - out_row = bank[rb] row rrow.
  - out_row_idx = rband*BLOCK_SIZE+rrow.
  - On handshake, rrow increments.
  - When rrow==BLOCK_SIZE-1: full[rb]<=0, rb toggles, rrow<=0, band_done pulses next cycle, rband increments.
- Frame wrap: on draining band ROW/BLOCK_SIZE-1, rband<=0 and frame_done pulses with band_done. The next frame continues with no reset required.
- Latency: last block of a band accepted at cycle t → out_valid=1 in cycle t+1.
- Throughput: 1 block/cycle in, 1 row/cycle out. Steady state is limited by the slower side.
- Full condition: both banks full → in_ready=0. Data and flags are held and no block is lost.
- Empty condition: out_valid=0. out_row is don't-care.
- Simultaneous events: in the same cycle, one bank can finish filling while the other finishes draining. Set and clear hit different banks and both take effect. A bank freed in cycle t is writable in cycle t+1, not in cycle t.
- out_valid, once high, stays high and out_row stays stable until the handshake.

Optional Feature:
R2N_LAST_EN: when defined, adds output port out_last (1 bit), high with out_valid when out_row_idx==ROW-1. When undefined, the port and its logic are absent. frame_done is present in both builds.

Test Plan:
Test parameters: ROW=4, COL=8, BLOCK_SIZE=2, CHUNK_SIZE=4, WIDTH=16. Element value = r*8+c.
- Stream 4 blocks back-to-back with out_ready=1 → 4 rows, idx 0..3. Row 0 = {0,1,...,7} with column 0 at MSB. First out_valid 1 cycle after block 1 accept. band_done pulses twice; frame_done pulses once after row 3.
- Hold out_ready=0 and send 4 blocks → in_ready drops after the 4th accept. A 5th in_valid stalls. Release out_ready → rows 0..3 emerge in order, then in_ready=1.
- Random out_ready (50%) and in_valid (50%) over 3 frames → rows exact and in order, idx wraps 3→0, frame_done count=3.
- Assert rst after 3 blocks accepted → out_valid=0 and in_ready=0 during rst. After release, a full frame produces only new data starting at idx 0.
- Bank 0 draining its last row while bank 1 takes its last block in the same cycle → next cycle out_valid=1 with row idx 2, and in_ready=1.
- With R2N_LAST_EN defined → out_last=1 only on idx 3. Without it → build passes with no out_last port.
